// File: rtl/mem_responder.sv
// mem_responder: single-port 16-bit word memory acting as the target of the
// CPU memory bus. It owns the program load phase (holding the CPU in reset),
// services CPU reads/writes while the program runs, and streams the whole
// memory image out over a valid/ready dump port once the CPU signals the end
// of its program.
module mem_responder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mem_enable_i,
   input  logic                  mem_rd_en_i,
   input  logic                  mem_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [15:0]           mem_value_i,
   output logic [15:0]           mem_value_o,
   input  logic                  end_program_i,
   output logic                  cpu_rst_o,
   input  logic                  load_valid_i,
   output logic                  load_ready_o,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [15:0]           load_data_i,
   input  logic                  load_done_i,
   output logic                  dump_valid_o,
   input  logic                  dump_ready_i,
   output logic [ADDR_WIDTH-1:0] dump_addr_o,
   output logic [15:0]           dump_data_o,
   output logic                  dump_done_o,
   output logic [15:0]           rd_count_o,
   output logic [15:0]           wr_count_o,
   output logic                  protocol_err_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      RUN    = 3'd1,
      DFETCH = 3'd2,
      DSEND  = 3'd3,
      DONE   = 3'd4
   } state_e;

   state_e state_q;

   // Storage array; deliberately without reset so contents survive rst_i.
   logic [15:0] mem [DEPTH];

   // Single shared memory port, steered by the current phase.
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [15:0]           memWdata;
   logic [15:0]           memRdata;
   logic                  memWe;

   // Qualified CPU bus events, only meaningful while running.
   logic cpuRead;
   logic cpuWrite;
   logic protoViolation;

   // Registered outputs and dump bookkeeping.
   logic [15:0]           memValue_q;
   logic                  cpuRst_q;
   logic                  loadReady_q;
   logic                  dumpValid_q;
   logic                  dumpDone_q;
   logic [ADDR_WIDTH-1:0] dumpPtr_q;
   logic [15:0]           dumpData_q;

   // Statistics and sticky error, with next-state values.
   logic [15:0] rdCount_q;
   logic [15:0] rdCount_d;
   logic [15:0] wrCount_q;
   logic [15:0] wrCount_d;
   logic        protoErr_q;
   logic        protoErr_d;

   // Decide who owns the memory port this cycle: loader, CPU or dump pointer.
   always_comb begin
      memAddr        = dumpPtr_q;
      memWdata       = 16'h0000;
      memWe          = 1'b0;
      cpuRead        = 1'b0;
      cpuWrite       = 1'b0;
      protoViolation = 1'b0;
      case (state_q)
         LOAD: begin
            memAddr  = load_addr_i;
            memWdata = load_data_i;
            memWe    = load_valid_i && loadReady_q;
         end
         RUN: begin
            memAddr        = mem_addr_i;
            memWdata       = mem_value_i;
            cpuRead        = mem_enable_i && mem_rd_en_i;
            cpuWrite       = mem_enable_i && mem_wr_en_i;
            memWe          = cpuWrite;
            protoViolation = !mem_enable_i && (mem_rd_en_i || mem_wr_en_i);
         end
         default: begin
            memAddr = dumpPtr_q;
         end
      endcase
   end

   assign memRdata = mem[memAddr];

   // Array write; a write landing on an edge while reset is asserted is dropped.
   always_ff @(posedge clk_i) begin
      if (memWe && !rst_i) begin
         mem[memAddr] <= memWdata;
      end
   end

   // Saturating access counters and the sticky protocol error flag.
   always_comb begin
      rdCount_d  = rdCount_q;
      wrCount_d  = wrCount_q;
      protoErr_d = protoErr_q;
      if (cpuRead && (rdCount_q != COUNT_MAX)) begin
         rdCount_d = rdCount_q + 16'd1;
      end
      if (cpuWrite && (wrCount_q != COUNT_MAX)) begin
         wrCount_d = wrCount_q + 16'd1;
      end
      if (protoViolation) begin
         protoErr_d = 1'b1;
      end
   end

   // Register the counters and error flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdCount_q  <= 16'h0000;
         wrCount_q  <= 16'h0000;
         protoErr_q <= 1'b0;
      end else begin
         rdCount_q  <= rdCount_d;
         wrCount_q  <= wrCount_d;
         protoErr_q <= protoErr_d;
      end
   end

   // Phase sequencer: load, run, then fetch/send each word until the image is out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= LOAD;
         memValue_q  <= 16'h0000;
         cpuRst_q    <= 1'b1;
         loadReady_q <= 1'b1;
         dumpValid_q <= 1'b0;
         dumpDone_q  <= 1'b0;
         dumpPtr_q   <= '0;
         dumpData_q  <= 16'h0000;
      end else begin
         case (state_q)
            LOAD: begin
               if (load_done_i) begin
                  state_q     <= RUN;
                  cpuRst_q    <= 1'b0;
                  loadReady_q <= 1'b0;
               end
            end
            RUN: begin
               if (cpuRead) begin
                  memValue_q <= memRdata;
               end
               if (end_program_i) begin
                  state_q   <= DFETCH;
                  dumpPtr_q <= '0;
               end
            end
            DFETCH: begin
               dumpData_q  <= memRdata;
               dumpValid_q <= 1'b1;
               state_q     <= DSEND;
            end
            DSEND: begin
               if (dump_ready_i) begin
                  dumpValid_q <= 1'b0;
                  if (dumpPtr_q == LAST_ADDR) begin
                     state_q    <= DONE;
                     dumpDone_q <= 1'b1;
                  end else begin
                     dumpPtr_q <= dumpPtr_q + 1'b1;
                     state_q   <= DFETCH;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign mem_value_o    = memValue_q;
   assign cpu_rst_o      = cpuRst_q;
   assign load_ready_o   = loadReady_q;
   assign dump_valid_o   = dumpValid_q;
   assign dump_addr_o    = dumpPtr_q;
   assign dump_data_o    = dumpData_q;
   assign dump_done_o    = dumpDone_q;
   assign rd_count_o     = rdCount_q;
   assign wr_count_o     = wrCount_q;
   assign protocol_err_o = protoErr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors for the CPU-facing behaviour of an
// 8-bit-address instance, plus hand-written dump sequences on a 2-bit-address
// instance where the whole image is short enough to follow word by word.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rstSmall;

   logic        memEnable;
   logic        memRdEn;
   logic        memWrEn;
   logic [7:0]  memAddr;
   logic [15:0] memValueIn;
   logic [15:0] memValueOut;
   logic        endProgram;
   logic        cpuRst;
   logic        loadValid;
   logic        loadReady;
   logic [7:0]  loadAddr;
   logic [15:0] loadData;
   logic        loadDone;
   logic        dumpValid;
   logic        dumpReady;
   logic [7:0]  dumpAddr;
   logic [15:0] dumpData;
   logic        dumpDone;
   logic [15:0] rdCount;
   logic [15:0] wrCount;
   logic        protoErr;

   logic        sLoadValid;
   logic        sLoadReady;
   logic [1:0]  sLoadAddr;
   logic [15:0] sLoadData;
   logic        sLoadDone;
   logic        sEndProgram;
   logic        sCpuRst;
   logic        sDumpValid;
   logic        sDumpReady;
   logic [1:0]  sDumpAddr;
   logic [15:0] sDumpData;
   logic        sDumpDone;
   logic [15:0] sMemValueOut;
   logic [15:0] sRdCount;
   logic [15:0] sWrCount;
   logic        sProtoErr;

   int vecCount  = 0;
   int missCount = 0;

   logic [15:0] smallImage [4];

   typedef struct {
      logic        lv;
      logic [7:0]  la;
      logic [15:0] ld;
      logic        done;
      logic        en;
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] val;
      logic        endp;
      logic [15:0] expMem;
      logic [15:0] expRd;
      logic [15:0] expWr;
      logic        expErr;
      logic        expCpuRst;
   } vec_t;

   vec_t vecs [22];

   mem_responder #(.ADDR_WIDTH(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mem_enable_i   (memEnable),
      .mem_rd_en_i    (memRdEn),
      .mem_wr_en_i    (memWrEn),
      .mem_addr_i     (memAddr),
      .mem_value_i    (memValueIn),
      .mem_value_o    (memValueOut),
      .end_program_i  (endProgram),
      .cpu_rst_o      (cpuRst),
      .load_valid_i   (loadValid),
      .load_ready_o   (loadReady),
      .load_addr_i    (loadAddr),
      .load_data_i    (loadData),
      .load_done_i    (loadDone),
      .dump_valid_o   (dumpValid),
      .dump_ready_i   (dumpReady),
      .dump_addr_o    (dumpAddr),
      .dump_data_o    (dumpData),
      .dump_done_o    (dumpDone),
      .rd_count_o     (rdCount),
      .wr_count_o     (wrCount),
      .protocol_err_o (protoErr)
   );

   mem_responder #(.ADDR_WIDTH(2)) dutSmall (
      .clk_i          (clk),
      .rst_i          (rstSmall),
      .mem_enable_i   (1'b0),
      .mem_rd_en_i    (1'b0),
      .mem_wr_en_i    (1'b0),
      .mem_addr_i     (2'b00),
      .mem_value_i    (16'h0000),
      .mem_value_o    (sMemValueOut),
      .end_program_i  (sEndProgram),
      .cpu_rst_o      (sCpuRst),
      .load_valid_i   (sLoadValid),
      .load_ready_o   (sLoadReady),
      .load_addr_i    (sLoadAddr),
      .load_data_i    (sLoadData),
      .load_done_i    (sLoadDone),
      .dump_valid_o   (sDumpValid),
      .dump_ready_i   (sDumpReady),
      .dump_addr_o    (sDumpAddr),
      .dump_data_o    (sDumpData),
      .dump_done_o    (sDumpDone),
      .rd_count_o     (sRdCount),
      .wr_count_o     (sWrCount),
      .protocol_err_o (sProtoErr)
   );

   // Single scalar comparison, counted in the shared tallies.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   // Drive one table row onto the 8-bit instance.
   task automatic applyStimulus(input vec_t v);
      loadValid  = v.lv;
      loadAddr   = v.la;
      loadData   = v.ld;
      loadDone   = v.done;
      memEnable  = v.en;
      memRdEn    = v.rd;
      memWrEn    = v.wr;
      memAddr    = v.addr;
      memValueIn = v.val;
      endProgram = v.endp;
   endtask

   // Compare all CPU-side outputs against one table row as a single vector.
   task automatic checkVector(input int idx, input vec_t v);
      vecCount++;
      if (memValueOut !== v.expMem || rdCount !== v.expRd || wrCount !== v.expWr ||
          protoErr !== v.expErr || cpuRst !== v.expCpuRst) begin
         missCount++;
         $display("[TB] FAIL vector %0d: memValue %h/%h rd %0d/%0d wr %0d/%0d err %b/%b cpuRst %b/%b (got/want)",
                  idx, memValueOut, v.expMem, rdCount, v.expRd, wrCount, v.expWr,
                  protoErr, v.expErr, cpuRst, v.expCpuRst);
      end
   endtask

   // Apply a slice of the table, one clock per row, checking after each edge.
   task automatic runVectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkVector(i, vecs[i]);
      end
      applyStimulus('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0,
                      16'h0000, 16'd0, 16'd0, 1'b0, 1'b0});
   endtask

   // Wait for a dump word on the small instance, check it, optionally stall, then accept it.
   task automatic smallDumpWord(input int idx, input logic [15:0] exp, input int stall);
      int waitCnt = 0;
      while (sDumpValid !== 1'b1 && waitCnt < 4) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      checkOutput($sformatf("small dump valid w%0d", idx), 32'(sDumpValid), 32'd1);
      checkOutput($sformatf("small dump addr w%0d", idx), 32'(sDumpAddr), 32'(idx));
      checkOutput($sformatf("small dump data w%0d", idx), 32'(sDumpData), 32'(exp));
      for (int s = 0; s < stall; s++) begin
         sDumpReady = 1'b0;
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall valid w%0d c%0d", idx, s), 32'(sDumpValid), 32'd1);
         checkOutput($sformatf("stall addr w%0d c%0d", idx, s), 32'(sDumpAddr), 32'(idx));
         checkOutput($sformatf("stall data w%0d c%0d", idx, s), 32'(sDumpData), 32'(exp));
      end
      sDumpReady = 1'b1;
      @(posedge clk);
      #1;
      sDumpReady = 1'b0;
   endtask

   // Hard stop in case a sequence wedges outside its own bounded waits.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1);
   end

   // Main sequence.
   initial begin
      int waitCnt;
      int cyc;
      int firstValid;
      int wordsSeen;

      smallImage[0] = 16'd11;
      smallImage[1] = 16'd22;
      smallImage[2] = 16'd33;
      smallImage[3] = 16'd44;

      // CPU-side vector table: first block runs from power-up, rows 15..21 follow a mid-dump reset.
      vecs[0]  = '{1'b1, 8'h03, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 8'h05, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 8'h07, 16'h0BEE, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'hA5A5, 16'd1, 16'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 16'h1234, 1'b0, 16'hA5A5, 16'd1, 16'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1234, 16'd2, 16'd1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 16'h0002, 1'b0, 16'h0001, 16'd3, 16'd2, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0002, 16'd4, 16'd2, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 16'hDEAD, 1'b0, 16'h0002, 16'd4, 16'd2, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0002, 16'd4, 16'd2, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 16'h0000, 1'b0, 16'h0BEE, 16'd5, 16'd2, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 8'h03, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'hA5A5, 16'd6, 16'd2, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'hA5A5, 16'd7, 16'd2, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 16'h0000, 1'b0, 16'hA5A5, 16'd7, 16'd2, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h1234, 16'd8, 16'd2, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'hA5A5, 16'd1, 16'd0, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0002, 16'd2, 16'd0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 16'h0000, 1'b0, 16'h0BEE, 16'd3, 16'd0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1234, 16'd4, 16'd0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 16'h4242, 1'b0, 16'h1234, 16'd4, 16'd1, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 16'h0000, 1'b0, 16'h4242, 16'd5, 16'd1, 1'b0, 1'b0};

      rst = 1'b1;
      rstSmall = 1'b1;
      memEnable = 1'b0; memRdEn = 1'b0; memWrEn = 1'b0; memAddr = 8'h00; memValueIn = 16'h0000;
      endProgram = 1'b0; loadValid = 1'b0; loadAddr = 8'h00; loadData = 16'h0000; loadDone = 1'b0;
      dumpReady = 1'b0;
      sLoadValid = 1'b0; sLoadAddr = 2'b00; sLoadData = 16'h0000; sLoadDone = 1'b0;
      sEndProgram = 1'b0; sDumpReady = 1'b0;

      @(posedge clk);
      #1;
      checkOutput("reset memValue", 32'(memValueOut), 32'h0);
      checkOutput("reset cpuRst", 32'(cpuRst), 32'd1);
      checkOutput("reset loadReady", 32'(loadReady), 32'd1);
      checkOutput("reset dumpValid", 32'(dumpValid), 32'd0);
      checkOutput("reset dumpAddr", 32'(dumpAddr), 32'd0);
      checkOutput("reset dumpData", 32'(dumpData), 32'h0);
      checkOutput("reset dumpDone", 32'(dumpDone), 32'd0);
      checkOutput("reset rdCount", 32'(rdCount), 32'd0);
      checkOutput("reset wrCount", 32'(wrCount), 32'd0);
      checkOutput("reset protoErr", 32'(protoErr), 32'd0);
      rst = 1'b0;
      rstSmall = 1'b0;

      runVectors(0, 14);

      checkOutput("dump valid low in fetch", 32'(dumpValid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("dump valid two cycles after end", 32'(dumpValid), 32'd1);
      checkOutput("dump first addr", 32'(dumpAddr), 32'd0);

      dumpReady = 1'b1;
      memEnable = 1'b1; memWrEn = 1'b1; memAddr = 8'h03; memValueIn = 16'h5555;
      loadValid = 1'b1; loadAddr = 8'h05; loadData = 16'h6666;
      waitCnt = 0;
      while (!(dumpValid === 1'b1 && dumpAddr == 8'd2) && waitCnt < 20) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      dumpReady = 1'b0;
      memEnable = 1'b0; memWrEn = 1'b0; loadValid = 1'b0;
      checkOutput("reach dump word 2", 32'(dumpValid && dumpAddr == 8'd2), 32'd1);

      #3;
      rst = 1'b1;
      #1;
      checkOutput("midreset dumpValid", 32'(dumpValid), 32'd0);
      checkOutput("midreset cpuRst", 32'(cpuRst), 32'd1);
      checkOutput("midreset loadReady", 32'(loadReady), 32'd1);
      checkOutput("midreset dumpAddr", 32'(dumpAddr), 32'd0);
      checkOutput("midreset memValue", 32'(memValueOut), 32'h0);
      checkOutput("midreset rdCount", 32'(rdCount), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      runVectors(15, 21);

      for (int i = 0; i < 4; i++) begin
         sLoadValid = 1'b1;
         sLoadAddr  = 2'(i);
         sLoadData  = smallImage[i];
         sLoadDone  = (i == 3);
         @(posedge clk);
         #1;
      end
      sLoadValid = 1'b0;
      sLoadDone  = 1'b0;
      checkOutput("small cpuRst after done", 32'(sCpuRst), 32'd0);

      sEndProgram = 1'b1;
      @(posedge clk);
      #1;
      sEndProgram = 1'b0;
      checkOutput("small valid low in fetch", 32'(sDumpValid), 32'd0);

      smallDumpWord(0, smallImage[0], 0);
      smallDumpWord(1, smallImage[1], 3);
      smallDumpWord(2, smallImage[2], 0);
      smallDumpWord(3, smallImage[3], 0);
      checkOutput("small done after last", 32'(sDumpDone), 32'd1);
      checkOutput("small valid after last", 32'(sDumpValid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("small done holds", 32'(sDumpDone), 32'd1);
      checkOutput("small valid stays low", 32'(sDumpValid), 32'd0);

      rstSmall = 1'b1;
      #1;
      checkOutput("small reset done", 32'(sDumpDone), 32'd0);
      checkOutput("small reset cpuRst", 32'(sCpuRst), 32'd1);
      @(posedge clk);
      #1;
      rstSmall = 1'b0;
      sLoadDone = 1'b1;
      @(posedge clk);
      #1;
      sLoadDone = 1'b0;
      sEndProgram = 1'b1;
      sDumpReady = 1'b1;
      @(posedge clk);
      #1;
      sEndProgram = 1'b0;
      cyc = 0;
      firstValid = -1;
      wordsSeen = 0;
      while (sDumpDone !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (sDumpValid === 1'b1) begin
            if (firstValid < 0) firstValid = cyc;
            checkOutput($sformatf("stream addr %0d", wordsSeen), 32'(sDumpAddr), 32'(wordsSeen));
            checkOutput($sformatf("stream data %0d", wordsSeen), 32'(sDumpData), 32'(smallImage[sDumpAddr]));
            wordsSeen++;
         end
      end
      sDumpReady = 1'b0;
      checkOutput("stream first valid cycle", 32'(firstValid), 32'd1);
      checkOutput("stream done cycle", 32'(cyc), 32'd8);
      checkOutput("stream word count", 32'(wordsSeen), 32'd4);
      checkOutput("stream done flag", 32'(sDumpDone), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port 16-bit word memory that answers the CPU's memory interface (enable / read-enable / write-enable / address / data) as the target side of the bus. It sits between the CPU top and the testbench or host. It owns the program load phase and holds the CPU in reset until loading is finished. After the CPU signals end of program, it streams the full memory image out over a valid/ready dump port for result checking.

## Interface
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words of 16 bits
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- mem_enable_i  in  1  CPU bus access strobe
- mem_rd_en_i  in  1  CPU read request
- mem_wr_en_i  in  1  CPU write request
- mem_addr_i  in  ADDR_WIDTH  CPU word address
- mem_value_i  in  16  CPU write data
- mem_value_o  out  16  read data to CPU
- end_program_i  in  1  CPU end-of-program flag
- cpu_rst_o  out  1  holds CPU in reset while loading
- load_valid_i  in  1  loader word valid
- load_ready_o  out  1  loader word accepted when valid&ready
- load_addr_i  in  ADDR_WIDTH  loader address
- load_data_i  in  16  loader data
- load_done_i  in  1  loader finished
- dump_valid_o  out  1  dump word valid
- dump_ready_i  in  1  dump consumer ready
- dump_addr_o  out  ADDR_WIDTH  address of dump word
- dump_data_o  out  16  dump word
- dump_done_o  out  1  full image dumped
- rd_count_o  out  16  serviced CPU reads, saturating
- wr_count_o  out  16  serviced CPU writes, saturating
- protocol_err_o  out  1  sticky bus protocol error

## Operation
- FSM states: LOAD, RUN, DFETCH, DSEND, DONE. Reset enters LOAD.
- LOAD
  - load_ready_o=1 and cpu_rst_o=1.
  - Handshake valid&ready writes load_data_i to load_addr_i.
  - load_done_i goes to RUN. A load word presented in the same cycle as load_done_i is still written.
  - CPU port is ignored.
- RUN
  - A write happens when mem_enable_i && mem_wr_en_i.
  - A read happens when mem_enable_i && mem_rd_en_i. mem_value_o is registered and holds its value until the next read.
  - Read and write to the same address in the same cycle: the write is performed and the read returns the old data (read-before-write).
  - Each serviced read increments rd_count_o; each serviced write increments wr_count_o. Both saturate at 16'hFFFF.
  - protocol_err_o sets when mem_rd_en_i or mem_wr_en_i is high while mem_enable_i is low. It stays set until reset. The offending access is not performed.
  - end_program_i goes to DFETCH with the dump pointer at 0. A CPU access in the same cycle is still serviced.
- DFETCH
  - Reads memory at the dump pointer into dump_data_o.
  - Goes to DSEND next cycle.
- DSEND
  - dump_valid_o=1. dump_addr_o and dump_data_o are stable while valid is high and ready is low.
  - On dump_ready_i, if the pointer equals DEPTH-1, go to DONE; otherwise increment the pointer and go to DFETCH.
  - The pointer never wraps.
- DONE
  - dump_done_o=1 and dump_valid_o=0.
  - Remains in DONE until reset.
- cpu_rst_o is 0 in RUN, DFETCH, DSEND and DONE.
- The CPU port and the load port are ignored in DFETCH, DSEND and DONE.
- Memory array has no reset. Contents are undefined at power-up and retained across rst_i.

## Timing
- Reset values:
  - mem_value_o=0, cpu_rst_o=1, load_ready_o=1
  - dump_valid_o=0, dump_addr_o=0, dump_data_o=0, dump_done_o=0
  - rd_count_o=0, wr_count_o=0, protocol_err_o=0
- Reset asserted mid-operation (any state): outputs return to reset values immediately (asynchronous) and the FSM goes to LOAD. Writes in flight at that edge are dropped.
- Loader write latency is 0: data is visible to a read accepted on the next cycle.
- cpu_rst_o falls the cycle after load_done_i is sampled.
- CPU read latency is 1: rd_en sampled at edge N produces data on mem_value_o after edge N.
- Dump entry: dump_valid_o first rises 2 cycles after end_program_i is sampled (RUN to DFETCH to DSEND).
- Dump throughput: at most one word per 2 cycles. A full dump takes 2*DEPTH cycles when ready is held high.
- dump_done_o rises the cycle after the final handshake.
- All outputs are registered or decoded directly from FSM state. There is no combinational path from inputs to outputs.

## Test plan
- Load and readback:
  - Stimulus: load 16'hA5A5 to addr 3, then load_done_i; CPU reads addr 3.
  - Required: cpu_rst_o falls one cycle after load_done_i; mem_value_o=16'hA5A5 one cycle after the read; rd_count_o=1.
- Write then read:
  - Stimulus: CPU writes 16'h1234 to addr 8'hFF, then reads 8'hFF.
  - Required: read returns 16'h1234; wr_count_o=1, rd_count_o=1.
- Simultaneous read and write:
  - Stimulus: addr 5 holds 16'h0001; CPU asserts rd and wr of 16'h0002 to addr 5 in one cycle, then reads addr 5.
  - Required: first read returns 16'h0001, second returns 16'h0002.
- Protocol error:
  - Stimulus: mem_wr_en_i=1 with mem_enable_i=0, data 16'hDEAD to addr 7.
  - Required: protocol_err_o=1 and stays set; addr 7 unchanged; wr_count_o unchanged.
- Dump with backpressure:
  - Stimulus: ADDR_WIDTH=2, memory preloaded with {11,22,33,44}; assert end_program_i; hold dump_ready_i low 3 cycles on the second word.
  - Required: words appear in order 0..3 with the correct data; the second word is held stable during the stall; dump_done_o=1 after word 3; dump_valid_o=0 afterwards.
- Reset mid-dump:
  - Stimulus: assert rst_i during DSEND.
  - Required: dump_valid_o=0, cpu_rst_o=1, load_ready_o=1 immediately; memory contents unchanged when read back after a new load_done_i.
